// File: rtl/sync_fifo.sv
// Parametrised single-clock FIFO with ready/valid handshakes on both sides.
// OUT_REG=1 places a synchronous-read output register (block-RAM style) in front of deq.
module sync_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AWIDTH   = $clog2(DEPTH),
  parameter int OUT_REG  = 0,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  enq_data,
  input  logic              enq_valid,
  output logic              enq_ready,
  output logic [WIDTH-1:0]  deq_data,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [AWIDTH:0]   count,
  output logic              almost_full,
  output logic              almost_empty
);
  localparam logic [AWIDTH:0]   FULL_CNT = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0]   AF_CNT   = (AWIDTH+1)'(AF_LEVEL);
  localparam logic [AWIDTH:0]   AE_CNT   = (AWIDTH+1)'(AE_LEVEL);
  localparam logic [AWIDTH:0]   CNT_ONE  = (AWIDTH+1)'(1);
  localparam logic [AWIDTH-1:0] PTR_ONE  = AWIDTH'(1);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [AWIDTH-1:0] r_wr_ptr;
  logic [AWIDTH-1:0] r_rd_ptr;
  logic [AWIDTH:0]   r_count;
  logic              w_enq_fire;
  logic              w_deq_fire;
  logic              w_rd_issue;

  // count includes the output register and any in-flight read, so ready never sees deq_ready.
  assign enq_ready    = (r_count < FULL_CNT);
  assign w_enq_fire   = enq_valid && enq_ready;
  assign w_deq_fire   = deq_valid && deq_ready;
  assign count        = r_count;
  assign almost_full  = (r_count >= AF_CNT);
  assign almost_empty = (r_count <= AE_CNT);

  always_ff @(posedge clk) begin
    if (w_enq_fire) r_mem[r_wr_ptr] <= enq_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq_fire) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_issue) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_enq_fire, w_deq_fire})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  if (OUT_REG == 0) begin : g_async
    assign w_rd_issue = w_deq_fire;
    assign deq_valid  = (r_count != '0);
    assign deq_data   = r_mem[r_rd_ptr];
  end else begin : g_oreg
    logic [AWIDTH:0]  r_mem_cnt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;

    // Refill the output register when it is empty or being drained this cycle.
    assign w_rd_issue = (r_mem_cnt != '0) && (!r_out_valid || w_deq_fire);
    assign deq_valid  = r_out_valid;
    assign deq_data   = r_out_data;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_mem_cnt   <= '0;
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
      end else begin
        case ({w_enq_fire, w_rd_issue})
          2'b10:   r_mem_cnt <= r_mem_cnt + CNT_ONE;
          2'b01:   r_mem_cnt <= r_mem_cnt - CNT_ONE;
          default: r_mem_cnt <= r_mem_cnt;
        endcase
        if (w_rd_issue) begin
          r_out_valid <= 1'b1;
          r_out_data  <= r_mem[r_rd_ptr];
        end else if (w_deq_fire) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Drives one stimulus stream into both OUT_REG modes; each instance has its own
// queue-based reference model and a negedge monitor comparing every output.
module tb_sync_fifo;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      enq_data;
  logic            enq_valid;
  logic            deq_ready;
  logic [1:0]      enq_ready;
  logic [1:0]      deq_valid;
  logic [1:0]      af;
  logic [1:0]      ae;
  logic [1:0][7:0] deq_data;
  logic [1:0][4:0] count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    int         e;
  } ent_t;

  for (genvar m = 0; m < 2; m++) begin : g
    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH), .OUT_REG(m), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
      .clk(clk), .rst(rst),
      .enq_data(enq_data), .enq_valid(enq_valid), .enq_ready(enq_ready[m]),
      .deq_data(deq_data[m]), .deq_valid(deq_valid[m]), .deq_ready(deq_ready),
      .count(count[m]), .almost_full(af[m]), .almost_empty(ae[m])
    );

    // Model: a word is visible once it is past its read latency and its predecessor has left.
    ent_t q[$];
    int   n        = 0;
    int   last_deq = 0;
    int   head_l   = 0;
    int   nacc     = 0;

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        q.delete();
        last_deq = 0;
      end else begin
        bit   ef;
        bit   df;
        bit   was_empty;
        ent_t t;
        n++;
        df = deq_ready && (q.size() > 0) && (head_l <= n - 1);
        ef = enq_valid && (q.size() < DEPTH);
        was_empty = (q.size() == 0);
        if (df) begin
          void'(q.pop_front());
          last_deq = n;
        end
        if (ef) begin
          t.d = enq_data;
          t.e = n;
          q.push_back(t);
          nacc++;
        end
        if ((q.size() > 0) && (df || was_empty))
          head_l = (q[0].e + m > last_deq) ? q[0].e + m : last_deq;
      end
    end

    always @(negedge clk) begin
      if (!rst) begin
        bit mv;
        mv = (q.size() > 0) && (head_l <= n);
        chk($sformatf("m%0d enq_ready", m), enq_ready[m], q.size() < DEPTH);
        chk($sformatf("m%0d deq_valid", m), deq_valid[m], mv);
        chk($sformatf("m%0d count", m), count[m], q.size());
        chk($sformatf("m%0d almost_full", m), af[m], q.size() >= AF);
        chk($sformatf("m%0d almost_empty", m), ae[m], q.size() <= AE);
        if (mv) chk($sformatf("m%0d deq_data", m), deq_data[m], q[0].d);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s m%0d enq_ready", tag, m), enq_ready[m], 1);
      chk($sformatf("%s m%0d deq_valid", tag, m), deq_valid[m], 0);
      chk($sformatf("%s m%0d count", tag, m), count[m], 0);
      chk($sformatf("%s m%0d almost_full", tag, m), af[m], 0);
      chk($sformatf("%s m%0d almost_empty", tag, m), ae[m], 1);
    end
    chk($sformatf("%s m1 deq_data", tag), deq_data[1], 0);
  endtask

  initial begin
    int guard;
    int a0;
    int a1;
    rst = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0; enq_data = '0;
    void'($urandom(32'd20240611));
    #1 rst = 1'b1;
    #2 chk_reset_outputs("reset");
    step(); step();
    rst = 1'b0;

    // Fill 0x00..0x0F with the consumer stalled.
    for (int i = 0; i < DEPTH; i++) begin
      enq_data = 8'(i); enq_valid = 1'b1;
      step();
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("fill m%0d count", m), count[m], i + 1);
        chk($sformatf("fill m%0d almost_full", m), af[m], (i + 1) >= AF);
        chk($sformatf("fill m%0d almost_empty", m), ae[m], (i + 1) <= AE);
      end
    end
    for (int m = 0; m < 2; m++) chk($sformatf("full m%0d enq_ready", m), enq_ready[m], 0);

    // 17th word must be refused.
    enq_data = 8'hAA;
    step();
    for (int m = 0; m < 2; m++) chk($sformatf("reject m%0d count", m), count[m], DEPTH);

    // Full with simultaneous enq/deq: only the deq fires.
    enq_data = 8'h55; deq_ready = 1'b1;
    step();
    enq_valid = 1'b0;
    for (int m = 0; m < 2; m++) chk($sformatf("full+deq m%0d count", m), count[m], DEPTH - 1);
    repeat (20) step();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("drain m%0d count", m), count[m], 0);
      chk($sformatf("drain m%0d almost_empty", m), ae[m], 1);
    end

    // Latency of a single word into an empty FIFO.
    deq_ready = 1'b0; enq_data = 8'h3C; enq_valid = 1'b1;
    step();
    enq_valid = 1'b0;
    chk("lat m0 deq_valid t", deq_valid[0], 1);
    chk("lat m0 deq_data", deq_data[0], 8'h3C);
    chk("lat m1 deq_valid t", deq_valid[1], 0);
    step();
    chk("lat m1 deq_valid t+1", deq_valid[1], 1);
    chk("lat m1 deq_data", deq_data[1], 8'h3C);
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;

    // Random traffic until each instance has accepted 40 more words.
    a0 = g[0].nacc; a1 = g[1].nacc; guard = 0;
    while (((g[0].nacc - a0) < 40 || (g[1].nacc - a1) < 40) && guard < 2000) begin
      enq_valid = ($urandom_range(0, 3) != 0);
      enq_data  = 8'($urandom);
      deq_ready = ($urandom_range(0, 2) != 0);
      step();
      guard++;
    end
    chk("random phase within budget", guard < 2000, 1);
    enq_valid = 1'b0; deq_ready = 1'b1;
    repeat (24) step();
    for (int m = 0; m < 2; m++) chk($sformatf("random drain m%0d count", m), count[m], 0);

    // Reset in the middle of operation with 7 entries held.
    deq_ready = 1'b0; enq_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      enq_data = 8'(8'h70 + i);
      step();
    end
    enq_valid = 1'b0;
    step();
    for (int m = 0; m < 2; m++) chk($sformatf("pre-reset m%0d count", m), count[m], 7);
    #1 rst = 1'b1;
    #1 chk_reset_outputs("mid reset");
    rst = 1'b0;
    enq_data = 8'h11; enq_valid = 1'b1;
    step();
    enq_valid = 1'b0;
    chk("post-reset m0 deq_data", deq_data[0], 8'h11);
    step();
    chk("post-reset m1 deq_data", deq_data[1], 8'h11);
    deq_ready = 1'b1;
    repeat (3) step();
    for (int m = 0; m < 2; m++) chk($sformatf("post-reset m%0d count", m), count[m], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
